router_pkt_tx: RTL and testbench

Store-and-forward packet transmitter that sources traffic into the 1x3 router's input port. Accepts a packet command (destination, length) and its payload bytes from a local producer, buffers the payload, then drives the router's `packet_valid` / `data_in` with the header, payload and parity bytes. Obeys the router's `busy` back-pressure. Counts router parity-error indications. Used as the ingress-side partner of the router and as the traffic source in router system benches.

---
 rtl/router_pkt_tx.sv | 172 +++++++++++++++++
 tb/tb_router_pkt_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: store-and-forward packet source that feeds the 1x3 router input port.
// Defining ROUTER_TX_PARITY_INJECT_EN adds inject_err, which flips parity bit 0 of a packet.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    output logic       cmd_ready,
`ifdef ROUTER_TX_PARITY_INJECT_EN
    input  logic       inject_err,
`endif
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       busy,
    input  logic       error,
    output logic       packet_valid,
    output logic [7:0] data_out,
    output logic       tx_done,
    output logic       cmd_err,
    output logic [7:0] err_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_PARITY  = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    logic [2:0] state;
    logic [1:0] addr_q;
    logic [5:0] len_q;
    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr;
    logic [7:0] parity;
    logic [3:0] gap_cnt;
    logic       error_q;
    logic [7:0] mem [0:63];

    logic       pl_fire;
    logic       consume;
    logic [5:0] last_idx;
    logic [5:0] rd_next;
    logic [7:0] parity_out;

    assign cmd_ready = (state == S_IDLE);
    assign pl_ready  = (state == S_LOAD);
    assign pl_fire   = pl_valid && (state == S_LOAD);
    assign consume   = !busy && ((state == S_HEADER) || (state == S_PAYLOAD) || (state == S_PARITY));
    assign last_idx  = len_q - 6'd1;
    assign rd_next   = rd_ptr + 6'd1;

`ifdef ROUTER_TX_PARITY_INJECT_EN
    logic inject_q;

    always_ff @(posedge clock) begin
        if (reset)
            inject_q <= 1'b0;
        else if (cmd_valid && cmd_ready)
            inject_q <= inject_err;
    end

    assign parity_out = parity ^ {7'd0, inject_q};
`else
    assign parity_out = parity;
`endif

    // Payload store has no reset: the write pointer alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (pl_fire)
            mem[wr_ptr] <= pl_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            addr_q       <= 2'd0;
            len_q        <= 6'd0;
            wr_ptr       <= 6'd0;
            rd_ptr       <= 6'd0;
            parity       <= 8'd0;
            gap_cnt      <= 4'd0;
            packet_valid <= 1'b0;
            data_out     <= 8'd0;
            tx_done      <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if ((cmd_addr == 2'd3) || (cmd_len == 6'd0)) begin
                            cmd_err <= 1'b1;
                        end else begin
                            addr_q <= cmd_addr;
                            len_q  <= cmd_len;
                            wr_ptr <= 6'd0;
                            rd_ptr <= 6'd0;
                            parity <= 8'd0;
                            state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (pl_fire) begin
                        if (wr_ptr == last_idx) begin
                            parity       <= parity ^ pl_data ^ {len_q, addr_q};
                            data_out     <= {len_q, addr_q};
                            packet_valid <= 1'b1;
                            state        <= S_HEADER;
                        end else begin
                            parity <= parity ^ pl_data;
                            wr_ptr <= wr_ptr + 6'd1;
                        end
                    end
                end
                S_HEADER: begin
                    if (consume) begin
                        data_out <= mem[6'd0];
                        rd_ptr   <= 6'd0;
                        state    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (consume) begin
                        if (rd_ptr == last_idx) begin
                            data_out     <= parity_out;
                            packet_valid <= 1'b0;
                            state        <= S_PARITY;
                        end else begin
                            data_out <= mem[rd_next];
                            rd_ptr   <= rd_next;
                        end
                    end
                end
                S_PARITY: begin
                    if (consume) begin
                        data_out <= 8'd0;
                        tx_done  <= 1'b1;
                        gap_cnt  <= 4'd0;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'(GAP_CYCLES - 1))
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt + 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Router error flag is counted on rising edges only and saturates at 255.
    always_ff @(posedge clock) begin
        if (reset) begin
            error_q <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            error_q <= error;
            if (error && !error_q && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: randomized scoreboard bench for router_pkt_tx.
// Stimulus pushes the expected router byte stream; a negedge monitor pops and compares it.
module tb_router_pkt_tx;

    localparam int GAP = 2;

    typedef struct {
        logic [7:0] data;
        logic       pv;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_addr = 2'd0;
    logic [5:0] cmd_len = 6'd0;
    logic       cmd_ready;
    logic [7:0] pl_data = 8'd0;
    logic       pl_valid = 1'b0;
    logic       pl_ready;
    logic       busy;
    logic       error = 1'b0;
    logic       packet_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       cmd_err;
    logic [7:0] err_cnt;
`ifdef ROUTER_TX_PARITY_INJECT_EN
    logic       inject_err = 1'b0;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   err_model = 0;
    bit   rand_busy = 1'b0;
    bit   busy_script[$];
    exp_t sb[$];
    logic [7:0] pay [0:63];
    bit   in_pkt = 1'b0;
    bit   chk_done = 1'b0;

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_ready    (cmd_ready),
`ifdef ROUTER_TX_PARITY_INJECT_EN
        .inject_err   (inject_err),
`endif
        .pl_data      (pl_data),
        .pl_valid     (pl_valid),
        .pl_ready     (pl_ready),
        .busy         (busy),
        .error        (error),
        .packet_valid (packet_valid),
        .data_out     (data_out),
        .tx_done      (tx_done),
        .cmd_err      (cmd_err),
        .err_cnt      (err_cnt)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Router-side back-pressure: scripted values first, otherwise random or idle.
    initial begin
        busy = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (busy_script.size() > 0)
                busy = busy_script.pop_front();
            else if (rand_busy)
                busy = ($urandom_range(0, 2) == 0);
            else
                busy = 1'b0;
        end
    end

    // Monitor: acts like the router input port, consuming a byte whenever busy is low.
    always @(negedge clock) begin
        if (reset) begin
            in_pkt   = 1'b0;
            chk_done = 1'b0;
        end else begin
            if (chk_done) begin
                checkOutput("tx_done_pulse", {7'd0, tx_done}, 8'd1);
                chk_done = 1'b0;
            end else if (tx_done) begin
                checkOutput("tx_done_spurious", {7'd0, tx_done}, 8'd0);
            end
            if (packet_valid || in_pkt) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got 0x%02h pv=%0b, expected no traffic", data_out, packet_valid);
                    in_pkt = 1'b0;
                end else begin
                    checkOutput("data_out", data_out, sb[0].data);
                    checkOutput("packet_valid", {7'd0, packet_valid}, {7'd0, sb[0].pv});
                    if (packet_valid)
                        in_pkt = 1'b1;
                    if (!busy) begin
                        if (!sb[0].pv) begin
                            in_pkt   = 1'b0;
                            chk_done = 1'b1;
                        end
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] addr, input logic [5:0] len, input logic inj,
                                 input bit bubbles, output int acc_cycle);
        int waitc;
        logic [7:0] hdr;
        logic [7:0] par;
        logic inj_eff;
        exp_t e;
        waitc = 0;
        acc_cycle = 0;
        while (!cmd_ready && waitc < 3000) begin
            @(posedge clock);
            #1;
            waitc++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_timeout", {7'd0, cmd_ready}, 8'd1);
            return;
        end
`ifdef ROUTER_TX_PARITY_INJECT_EN
        inject_err = inj;
        inj_eff = inj;
`else
        inj_eff = 1'b0;
        if (inj)
            $display("[TB] parity injection not built in; request ignored");
`endif
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        acc_cycle = cycle;
        if (addr == 2'd3 || len == 6'd0) begin
            checkOutput("cmd_err_pulse", {7'd0, cmd_err}, 8'd1);
            @(posedge clock);
            #1;
            checkOutput("cmd_err_clear", {7'd0, cmd_err}, 8'd0);
            checkOutput("illegal_no_pv", {7'd0, packet_valid}, 8'd0);
            checkOutput("illegal_cmd_ready", {7'd0, cmd_ready}, 8'd1);
            return;
        end
        checkOutput("cmd_err_legal", {7'd0, cmd_err}, 8'd0);
        checkOutput("load_pl_ready", {7'd0, pl_ready}, 8'd1);
        for (int i = 0; i < int'(len); i++) begin
            if (bubbles) begin
                while ($urandom_range(0, 3) == 0) begin
                    pl_valid = 1'b0;
                    @(posedge clock);
                    #1;
                end
            end
            pl_valid = 1'b1;
            pl_data  = pay[i];
            @(posedge clock);
            #1;
        end
        pl_valid = 1'b0;
        hdr = {len, addr};
        par = hdr;
        e.data = hdr;
        e.pv   = 1'b1;
        sb.push_back(e);
        for (int i = 0; i < int'(len); i++) begin
            par ^= pay[i];
            e.data = pay[i];
            sb.push_back(e);
        end
        e.data = par ^ {7'd0, inj_eff};
        e.pv   = 1'b0;
        sb.push_back(e);
    endtask

    task automatic pulseError(input int n);
        for (int i = 0; i < n; i++) begin
            error = 1'b1;
            @(posedge clock);
            #1;
            error = 1'b0;
            @(posedge clock);
            #1;
        end
        err_model = (err_model + n > 255) ? 255 : err_model + n;
    endtask

    initial begin
        int acc1;
        int acc2;
        int waitc;
        logic [1:0] ra;
        logic [5:0] rl;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_packet_valid", {7'd0, packet_valid}, 8'd0);
        checkOutput("rst_data_out", data_out, 8'h00);
        checkOutput("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        checkOutput("rst_pl_ready", {7'd0, pl_ready}, 8'd0);
        checkOutput("rst_tx_done", {7'd0, tx_done}, 8'd0);
        checkOutput("rst_cmd_err", {7'd0, cmd_err}, 8'd0);
        checkOutput("rst_err_cnt", err_cnt, 8'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        pulseError(3);
        checkOutput("err_cnt_small", err_cnt, 8'(err_model));

        // Abandon a packet partway through its payload load.
        cmd_valid = 1'b1;
        cmd_addr  = 2'd0;
        cmd_len   = 6'd5;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pl_valid = 1'b1;
            pl_data  = 8'(8'hA0 + i);
            @(posedge clock);
            #1;
        end
        pl_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        err_model = 0;
        reset = 1'b0;
        checkOutput("midrst_packet_valid", {7'd0, packet_valid}, 8'd0);
        checkOutput("midrst_data_out", data_out, 8'h00);
        checkOutput("midrst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        checkOutput("midrst_pl_ready", {7'd0, pl_ready}, 8'd0);
        checkOutput("midrst_err_cnt", err_cnt, 8'd0);

        // Normal packet immediately followed by the max-length packet.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        applyStimulus(2'd1, 6'd3, 1'b0, 1'b0, acc1);
        for (int i = 0; i < 63; i++) pay[i] = 8'(i);
        applyStimulus(2'd2, 6'd63, 1'b0, 1'b0, acc2);
        checkOutput("cmd_to_cmd_cycles", 8'(acc2 - acc1), 8'(2 * 3 + 2 + GAP + 1));

        // Back-pressure: hold the header 3 cycles and the parity byte 2 cycles.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        applyStimulus(2'd1, 6'd3, 1'b0, 1'b0, acc1);
        busy_script = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        applyStimulus(2'd3, 6'd5, 1'b0, 1'b0, acc1);
        applyStimulus(2'd0, 6'd0, 1'b0, 1'b0, acc1);

        rand_busy = 1'b1;
        for (int k = 0; k < 15; k++) begin
            ra = 2'($urandom_range(0, 2));
            rl = 6'($urandom_range(1, 24));
            if ($urandom_range(0, 5) == 0) ra = 2'd3;
            for (int i = 0; i < int'(rl); i++) pay[i] = 8'($urandom);
            applyStimulus(ra, rl, 1'b0, 1'b1, acc1);
        end
        rand_busy = 1'b0;

`ifdef ROUTER_TX_PARITY_INJECT_EN
        pay[0] = 8'h5A;
        applyStimulus(2'd0, 6'd1, 1'b1, 1'b0, acc1);
        pay[0] = 8'h3C;
        applyStimulus(2'd0, 6'd1, 1'b0, 1'b0, acc1);
`endif

        pulseError(300);
        checkOutput("err_cnt_saturate", err_cnt, 8'(err_model));

        waitc = 0;
        while (sb.size() > 0 && waitc < 5000) begin
            @(posedge clock);
            #1;
            waitc++;
        end
        checkOutput("scoreboard_drained", 8'(sb.size()), 8'd0);
        repeat (4) @(posedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
